// File: rtl/aes_pkg.sv
// Shared AES constants, round-engine FSM encoding and GF(2^8) constant multipliers.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam logic       MODE_ENC = 1'b0;
    localparam logic       MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// Combinational MixColumn / InvMixColumn of one 32-bit column (byte a in the MSBs).
module aes_mixcol_col
    import aes_pkg::*;
#(
    parameter bit ENC_ONLY = 1'b0
) (
    input  logic [31:0] col,
    input  logic        mode,
    output logic [31:0] result
);

    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] fwd;

    assign {a0, a1, a2, a3} = col;

    assign fwd = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                  a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                  a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                  gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};

    if (ENC_ONLY) begin : g_enc
        logic unused_mode;
        assign unused_mode = mode;
        assign result      = fwd;
    end else begin : g_encdec
        logic [31:0] inv;
        assign inv = {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                      gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                      gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3),
                      gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3)};
        assign result = (mode == MODE_DEC) ? inv : fwd;
    end

endmodule

// File: rtl/aes_mixcol_iter.sv
// Iterative MixColumns/InvMixColumns over a 128-bit state, COLS columns per cycle,
// with valid/ready handshake and final-round bypass.
module aes_mixcol_iter
    import aes_pkg::*;
#(
    parameter int unsigned COLS     = 1,
    parameter bit          ENC_ONLY = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_mode,
    input  logic         i_bypass,
    input  logic [127:0] i_din,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_dout,
    output logic         o_busy
);

    if (!(COLS == 1 || COLS == 2 || COLS == 4)) begin : g_bad_cols
        $error("aes_mixcol_iter: COLS must be 1, 2 or 4");
    end

    state_t            state;
    logic [1:0]        cnt;
    logic              mode_q;
    logic [3:0][31:0]  st;          // st[3] is column 0 (bits 127:96)

    logic [1:0]        col_idx [COLS];
    logic [31:0]       col_in  [COLS];
    logic [31:0]       col_out [COLS];

    // Column c lives in st[3-c]; for a 2-bit index that is simply ~c
    for (genvar g = 0; g < COLS; g++) begin : g_col
        assign col_idx[g] = cnt + 2'(g);
        assign col_in[g]  = st[~col_idx[g]];

        aes_mixcol_col #(
            .ENC_ONLY (ENC_ONLY)
        ) u_col (
            .col    (col_in[g]),
            .mode   (mode_q),
            .result (col_out[g])
        );
    end

    assign o_ready = (state == IDLE) && i_rst_n;
    assign o_busy  = (state != IDLE);
    assign o_dout  = st;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= MODE_ENC;
            st      <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        st     <= i_din;
                        mode_q <= ENC_ONLY ? MODE_ENC : i_mode;
                        cnt    <= '0;
                        if (i_bypass) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    for (int unsigned g = 0; g < COLS; g++) begin
                        st[~col_idx[g]] <= col_out[g];
                    end
                    // Wraps to 0 on the final group, so cnt never points past column 3
                    cnt <= cnt + 2'(COLS);
                    if (cnt == 2'(4 - COLS)) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Self-checking bench: three engines (COLS = 1, 2, 4) against a generic GF(2^8) matrix model.
module tb_aes_mixcol_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         valid_in  [3];
    logic         ready_out [3];
    logic         mode_in   [3];
    logic         bypass_in [3];
    logic [127:0] din       [3];
    logic         valid_out [3];
    logic         ready_in  [3];
    logic [127:0] dout      [3];
    logic         busy_out  [3];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mixcol_iter #(
            .COLS     (1 << g),
            .ENC_ONLY (1'b0)
        ) u_dut (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_valid  (valid_in[g]),
            .o_ready  (ready_out[g]),
            .i_mode   (mode_in[g]),
            .i_bypass (bypass_in[g]),
            .i_din    (din[g]),
            .o_valid  (valid_out[g]),
            .i_ready  (ready_in[g]),
            .o_dout   (dout[g]),
            .o_busy   (busy_out[g])
        );
    end

    // Shift-and-add GF(2^8) product, reduced by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Circulant matrix times each column; row r uses coefficient coef[(k - r) mod 4] for byte k
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        int         coef [4];
        logic [7:0] acc;
        logic [127:0] r;
        if (inv) coef = '{14, 11, 13, 9};
        else     coef = '{2, 3, 1, 1};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(8'(coef[(k - row + 4) % 4]), s[127 - 32*c - 8*k -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on engine d; returns the result, edges from accept (inclusive)
    // to o_valid, and whether o_ready was seen high while the engine was working.
    task automatic run(input int d, input logic [127:0] x, input logic m, input logic byp,
                       input int max_gap, output logic [127:0] y, output int edges,
                       output logic ready_seen);
        int guard;
        @(negedge clk);
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        valid_in[d]  = 1'b1;
        din[d]       = x;
        mode_in[d]   = m;
        bypass_in[d] = byp;
        guard = 0;
        while (!ready_out[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 128'(ready_out[d]), 128'(1'b1));
        @(posedge clk);
        #1;
        valid_in[d]  = 1'b0;
        din[d]       = rand128();
        mode_in[d]   = ~m;
        bypass_in[d] = ~byp;
        edges = 1;
        ready_seen = 1'b0;
        while (!valid_out[d] && edges < 20) begin
            ready_seen = ready_seen | ready_out[d];
            @(posedge clk);
            #1;
            edges++;
        end
        check("valid_rise", 128'(valid_out[d]), 128'(1'b1));
        y = dout[d];
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
            check("gap_valid_hold", 128'(valid_out[d]), 128'(1'b1));
            check("gap_dout_hold", dout[d], y);
        end
        ready_in[d] = 1'b1;
        @(posedge clk);
        #1;
        ready_in[d] = 1'b0;
        check("valid_clear", 128'(valid_out[d]), 128'(1'b0));
    endtask

    task automatic roundtrip_batch(input int d, input int count);
        logic [127:0] x, y, z;
        int           e;
        logic         rs;
        for (int i = 0; i < count; i++) begin
            x = rand128();
            run(d, x, 1'b0, 1'b0, 3, y, e, rs);
            check("rt_fwd", y, ref_mix(x, 1'b0));
            check("rt_fwd_latency", 128'(e), 128'(4 / (1 << d) + 1));
            run(d, y, 1'b1, 1'b0, 3, z, e, rs);
            check("rt_inv_model", z, ref_mix(y, 1'b1));
            check("rt_identity", z, x);
        end
    endtask

    initial begin
        logic [127:0] y, x, held;
        int           e, guard;
        logic         rs;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            valid_in[d]  = 1'b0;
            mode_in[d]   = 1'b0;
            bypass_in[d] = 1'b0;
            din[d]       = '0;
            ready_in[d]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", 128'(valid_out[d]), 128'(1'b0));
            check("rst_dout", dout[d], '0);
            check("rst_ready", 128'(ready_out[d]), 128'(1'b0));
            check("rst_busy", 128'(busy_out[d]), 128'(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Forward, COLS = 4
        x = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        run(2, x, 1'b0, 1'b0, 0, y, e, rs);
        check("fwd4_dout", y, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        check("fwd4_model", y, ref_mix(x, 1'b0));
        check("fwd4_latency", 128'(e), 128'(2));

        // Inverse, COLS = 1
        x = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
        run(0, x, 1'b1, 1'b0, 0, y, e, rs);
        check("inv1_dout", y, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
        check("inv1_latency", 128'(e), 128'(5));
        check("inv1_ready_low", 128'(rs), 128'(1'b0));

        // Bypass then normal, COLS = 2
        x = 128'h00112233_44556677_8899aabb_ccddeeff;
        run(1, x, 1'b0, 1'b1, 0, y, e, rs);
        check("byp2_dout", y, x);
        check("byp2_latency", 128'(e), 128'(1));
        run(1, x, 1'b0, 1'b0, 0, y, e, rs);
        check("fwd2_changed", 128'(y !== x), 128'(1'b1));
        check("fwd2_model", y, ref_mix(x, 1'b0));
        check("fwd2_latency", 128'(e), 128'(3));

        // Backpressure in DONE with upstream still presenting new data, COLS = 4
        x = rand128();
        @(negedge clk);
        valid_in[2] = 1'b1;
        din[2]      = x;
        mode_in[2]  = 1'b0;
        bypass_in[2] = 1'b0;
        @(posedge clk);
        #1;
        guard = 0;
        while (!valid_out[2] && guard < 20) begin
            din[2] = rand128();
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_valid", 128'(valid_out[2]), 128'(1'b1));
        held = dout[2];
        check("bp_model", held, ref_mix(x, 1'b0));
        for (int i = 0; i < 10; i++) begin
            din[2]     = rand128();
            mode_in[2] = ~mode_in[2];
            @(posedge clk);
            #1;
            check("bp_valid_hold", 128'(valid_out[2]), 128'(1'b1));
            check("bp_dout_hold", dout[2], held);
            check("bp_busy", 128'(busy_out[2]), 128'(1'b1));
        end
        valid_in[2] = 1'b0;
        ready_in[2] = 1'b1;
        @(posedge clk);
        #1;
        ready_in[2] = 1'b0;
        check("bp_release", 128'(valid_out[2]), 128'(1'b0));
        check("bp_idle_ready", 128'(ready_out[2]), 128'(1'b1));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_no_second", 128'(busy_out[2]), 128'(1'b0));
        end

        // Asynchronous reset while COLS = 1 engine is at cnt = 1
        x = rand128();
        @(negedge clk);
        valid_in[0]  = 1'b1;
        din[0]       = x;
        mode_in[0]   = 1'b0;
        bypass_in[0] = 1'b0;
        @(posedge clk);
        #1;
        valid_in[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(valid_out[0]), 128'(1'b0));
        check("arst_dout", dout[0], '0);
        check("arst_ready", 128'(ready_out[0]), 128'(1'b0));
        check("arst_busy", 128'(busy_out[0]), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("arst_no_stale", 128'(valid_out[0]), 128'(1'b0));
        end
        run(0, x, 1'b0, 1'b0, 0, y, e, rs);
        check("arst_next", y, ref_mix(x, 1'b0));
        check("arst_next_latency", 128'(e), 128'(5));

        // Random round-trips on all three widths concurrently
        fork
            roundtrip_batch(0, 1000);
            roundtrip_batch(1, 1000);
            roundtrip_batch(2, 1000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
